hex_scan_ctrl: RTL and testbench

HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

---
 rtl/hex_scan_ctrl.sv | 103 ++++++++++
 tb/tb_hex_scan_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed hex display scanner with a one-entry load buffer.
// Latency: a load shows one cycle after accept when idle, else from the next frame; load_ready is low while a value is pending.
module hex_scan_ctrl #(
   parameter int unsigned TICK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        load_valid,
   input  logic [15:0] load_data,
   output logic        load_ready,
   input  logic        blank_lz,
   output logic [3:0]  dec_in,
   output logic [3:0]  digit_en,
   output logic        frame_done
);
   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TICK_DIV - 1);

   state_t      state_q, state_d;
   logic [15:0] disp_q, disp_d;
   logic [15:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  idx_q, idx_d;
   logic        slot_end;
   logic        frame_end;
   logic [3:0]  blank;

   assign slot_end  = (state_q == SCAN) && (cnt_q == CNT_LAST);
   assign frame_end = slot_end && (idx_q == 2'd3);

   always_comb begin
      state_d    = state_q;
      disp_d     = disp_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;

      if (load_valid && !pend_vld_q) begin
         pend_d     = load_data;
         pend_vld_d = 1'b1;
      end
      // Only swap the shown value between frames so a frame is never torn.
      if (pend_vld_q && ((state_q == IDLE) || frame_end)) begin
         disp_d     = pend_q;
         pend_vld_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            cnt_d = 16'd0;
            idx_d = 2'd0;
            if (enable) state_d = SCAN;
         end
         SCAN: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = 16'd0;
               idx_d   = 2'd0;
            end else if (slot_end) begin
               cnt_d = 16'd0;
               idx_d = idx_q + 2'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         disp_q     <= 16'd0;
         pend_q     <= 16'd0;
         pend_vld_q <= 1'b0;
         cnt_q      <= 16'd0;
         idx_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         disp_q     <= disp_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
      end
   end

   // Digit d is dark when it and every digit to its left are zero.
   assign blank[0] = 1'b0;
   assign blank[1] = blank_lz && (disp_q[15:4]  == 12'd0);
   assign blank[2] = blank_lz && (disp_q[15:8]  == 8'd0);
   assign blank[3] = blank_lz && (disp_q[15:12] == 4'd0);

   assign load_ready = ~pend_vld_q;
   assign dec_in     = disp_q[{idx_q, 2'b00} +: 4];
   assign frame_done = frame_end;
   assign digit_en   = ((state_q == SCAN) && !blank[idx_q]) ? ~(4'b0001 << idx_q) : 4'hF;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl at TICK_DIV = 4; per-cycle expectations
// for whole frames are queued up front and popped as the scan runs.
module tb_hex_scan_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load_data = 16'd0;
   logic        load_ready;
   logic        blank_lz = 1'b0;
   logic [3:0]  dec_in;
   logic [3:0]  digit_en;
   logic        frame_done;

   int n_cmp = 0;
   int n_err = 0;
   logic [15:0] sb[$];

   hex_scan_ctrl #(.TICK_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .blank_lz   (blank_lz),
      .dec_in     (dec_in),
      .digit_en   (digit_en),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One frame = 4 slots x 4 cycles; en holds the four digit_en codes, digit 0 in [3:0].
   task automatic push_frame(input logic [15:0] shown, input logic [15:0] en);
      for (int k = 0; k < 16; k++) begin
         int d;
         d = k / 4;
         sb.push_back({7'd0, shown[4*d +: 4], en[4*d +: 4], (k == 15)});
      end
   endtask

   task automatic sb_check(input string tag);
      logic [15:0] exp;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $error("FAIL %s: observed empty scoreboard expected entry", tag);
      end else begin
         exp = sb.pop_front();
         chk(tag, {7'd0, dec_in, digit_en, frame_done}, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #1;
      chk("rst_dec_in", {12'd0, dec_in}, 16'h0);
      chk("rst_digit_en", {12'd0, digit_en}, 16'hF);
      chk("rst_load_ready", {15'd0, load_ready}, 16'h1);
      chk("rst_frame_done", {15'd0, frame_done}, 16'h0);
      step();
      rst = 1'b0;

      // Idle load goes straight to the display one cycle after accept.
      load_valid = 1'b1;
      load_data  = 16'h1234;
      step();
      chk("idle_ready_low", {15'd0, load_ready}, 16'h0);
      chk("idle_disp_not_yet", {12'd0, dec_in}, 16'h0);
      load_valid = 1'b0;
      step();
      chk("idle_ready_back", {15'd0, load_ready}, 16'h1);
      chk("idle_dec_in", {12'd0, dec_in}, 16'h4);
      chk("idle_digit_en", {12'd0, digit_en}, 16'hF);
      chk("idle_frame_done", {15'd0, frame_done}, 16'h0);

      // Full frame of 1234.
      enable = 1'b1;
      push_frame(16'h1234, 16'h7BDE);
      for (int k = 0; k < 16; k++) begin
         step();
         sb_check("frame_1234");
      end

      // Load ABCD at idx 1, then hold 5555 against a full buffer.
      push_frame(16'h1234, 16'h7BDE);
      for (int k = 0; k < 16; k++) begin
         step();
         sb_check("frame_1234_hold");
         if (k >= 5) chk("pend_ready_low", {15'd0, load_ready}, 16'h0);
         if (k == 4) begin
            load_valid = 1'b1;
            load_data  = 16'hABCD;
         end
         if (k == 5) load_data = 16'h5555;
         if (k == 15) load_valid = 1'b0;
      end

      // ABCD from the next frame start; drop enable at idx 2.
      push_frame(16'hABCD, 16'h7BDE);
      for (int k = 0; k < 9; k++) begin
         step();
         sb_check("frame_abcd_part");
         if (k == 0) chk("abcd_ready_back", {15'd0, load_ready}, 16'h1);
      end
      sb.delete();
      enable = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         chk("off_digit_en", {12'd0, digit_en}, 16'hF);
         chk("off_frame_done", {15'd0, frame_done}, 16'h0);
         chk("off_dec_in_no_5555", {12'd0, dec_in}, 16'hD);
      end

      // Re-enable restarts at idx 0, cnt 0.
      enable = 1'b1;
      push_frame(16'hABCD, 16'h7BDE);
      for (int k = 0; k < 16; k++) begin
         step();
         sb_check("frame_abcd_restart");
      end
      enable = 1'b0;

      // Leading-zero blanking on 0050.
      step();
      load_valid = 1'b1;
      load_data  = 16'h0050;
      step();
      load_valid = 1'b0;
      step();
      chk("idle_0050_dark", {12'd0, digit_en}, 16'hF);
      blank_lz = 1'b1;
      enable   = 1'b1;
      push_frame(16'h0050, 16'hFFDE);
      for (int k = 0; k < 16; k++) begin
         step();
         sb_check("frame_0050_blank");
      end
      blank_lz = 1'b0;
      push_frame(16'h0050, 16'h7BDE);
      for (int k = 0; k < 16; k++) begin
         step();
         sb_check("frame_0050_noblank");
      end

      // Asynchronous reset mid-frame with a value pending.
      load_valid = 1'b1;
      load_data  = 16'h9999;
      step();
      load_valid = 1'b0;
      chk("pre_rst_ready_low", {15'd0, load_ready}, 16'h0);
      chk("pre_rst_digit_en", {12'd0, digit_en}, 16'hE);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_dec_in", {12'd0, dec_in}, 16'h0);
      chk("arst_digit_en", {12'd0, digit_en}, 16'hF);
      chk("arst_load_ready", {15'd0, load_ready}, 16'h1);
      chk("arst_frame_done", {15'd0, frame_done}, 16'h0);
      enable = 1'b0;
      step();
      rst = 1'b0;
      step();
      step();
      chk("post_rst_pend_lost", {12'd0, dec_in}, 16'h0);
      chk("post_rst_ready", {15'd0, load_ready}, 16'h1);
      chk("post_rst_digit_en", {12'd0, digit_en}, 16'hF);
      chk("sb_drained", 16'(sb.size()), 16'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
